// File: rtl/flags_bank.sv
// flags_bank: live/sticky ALU flag register with a masked IRQ/ACK handshake.
// Optional save/restore LIFO is compiled in when FLAGS_STACK_EN is defined.
module flags_bank #(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NFLAGS-1:0] in_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clr_sticky_i,
  input  logic [NFLAGS-1:0] irq_mask_i,
  input  logic              ack_i,
  output logic [NFLAGS-1:0] flags_o,
  output logic [NFLAGS-1:0] sticky_o,
  output logic              irq_o,
  output logic              stk_full_o,
  output logic              stk_empty_o,
  output logic              stk_err_o
);

  // state   | meaning
  // IDLE    | no request; raise IRQ when a masked sticky bit is set
  // ASSERT  | IRQ high, waiting for ACK
  // HOLDOFF | one quiet cycle after ACK before re-evaluating
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} irq_state_e;

  irq_state_e        state_q, state_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [NFLAGS-1:0] sticky_q, sticky_d;
  logic [NFLAGS-1:0] cap;
  logic              irq_q, irq_d;
  logic              stk_err_q, stk_err_d;
  logic              pend, ack_take;
  logic              pop_ok, err_evt;
  logic [NFLAGS-1:0] pop_data;

  assign cap  = in_i & {NFLAGS{en_i}};
  assign pend = |(sticky_q & irq_mask_i);

`ifdef FLAGS_STACK_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic [AW:0]       ptr_q, ptr_d;
  logic              full, empty, push_ok;

  assign full     = (ptr_q == (AW+1)'(DEPTH));
  assign empty    = (ptr_q == '0);
  assign push_ok  = push_i & ~pop_i & ~full;
  assign pop_ok   = pop_i & ~push_i & ~empty;
  assign err_evt  = (push_i & pop_i) | (push_i & full) | (pop_i & empty);
  assign pop_data = stack_q[AW'(ptr_q - (AW+1)'(1))];

  always_comb begin
    ptr_d = ptr_q;
    if (push_ok)     ptr_d = ptr_q + (AW+1)'(1);
    else if (pop_ok) ptr_d = ptr_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Stack storage is not reset; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (push_ok) stack_q[ptr_q[AW-1:0]] <= flags_q;
  end

  assign stk_full_o  = full;
  assign stk_empty_o = empty;
`else
  logic unused_stack;
  assign unused_stack = push_i | pop_i;
  assign pop_ok       = 1'b0;
  assign err_evt      = 1'b0;
  assign pop_data     = '0;
  assign stk_full_o   = 1'b0;
  assign stk_empty_o  = 1'b1;
`endif

  always_comb begin
    flags_d = flags_q;
    if (pop_ok)    flags_d = pop_data;
    else if (en_i) flags_d = in_i;

    stk_err_d = stk_err_q;
    if (clr_sticky_i) stk_err_d = 1'b0;
    if (err_evt)      stk_err_d = 1'b1;

    state_d  = state_q;
    irq_d    = irq_q;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend) begin
          state_d = ASSERT;
          irq_d   = 1'b1;
        end
      end
      ASSERT: begin
        if (ack_i) begin
          state_d  = HOLDOFF;
          irq_d    = 1'b0;
          ack_take = 1'b1;
        end else if (!pend) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      HOLDOFF: state_d = IDLE;
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase

    // A capture in the same cycle always survives the ACK or clear.
    sticky_d = sticky_q;
    if (ack_take)     sticky_d = sticky_q & ~irq_mask_i;
    if (clr_sticky_i) sticky_d = '0;
    sticky_d = sticky_d | cap;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      flags_q   <= '0;
      sticky_q  <= '0;
      irq_q     <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      sticky_q  <= sticky_d;
      irq_q     <= irq_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign flags_o   = flags_q;
  assign sticky_o  = sticky_q;
  assign irq_o     = irq_q;
  assign stk_err_o = stk_err_q;

endmodule

// File: tb/tb_flags_bank.sv
// Testbench for flags_bank: vector table, directed stack/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_flags_bank;
  localparam int NF = 4;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, push = 1'b0, pop = 1'b0, clr = 1'b0, ack = 1'b0;
  logic [NF-1:0] in_v = '0, mask = '0;
  logic [NF-1:0] flags, sticky;
  logic          irq, full, empty, err;

  int checks = 0;
  int failures = 0;

  logic [NF-1:0] m_flags, m_sticky;
  bit            m_irq, m_err;
  int            m_cool;
  logic [NF-1:0] m_stack[$];

  typedef struct {
    bit            en;
    logic [NF-1:0] in;
    bit            push, pop, clr;
    logic [NF-1:0] mask;
    bit            ack;
    logic [NF-1:0] ef, es;
    bit            ei;
  } vec_t;
  vec_t tbl[20];

  flags_bank #(.NFLAGS(NF), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .in_i(in_v), .push_i(push), .pop_i(pop),
    .clr_sticky_i(clr), .irq_mask_i(mask), .ack_i(ack),
    .flags_o(flags), .sticky_o(sticky), .irq_o(irq),
    .stk_full_o(full), .stk_empty_o(empty), .stk_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = '0; m_sticky = '0; m_irq = 0; m_err = 0; m_cool = 0;
    m_stack.delete();
  endtask

  // Reference: stack as a queue, IRQ as a flag plus a quiet-cycle countdown.
  task automatic model_step();
    logic [NF-1:0] nf, ns;
    bit nerr, evt, popped, pend;
    pend = |(m_sticky & mask);
    nf = m_flags; ns = m_sticky; nerr = m_err; evt = 0; popped = 0;
`ifdef FLAGS_STACK_EN
    if (push && pop) evt = 1;
    else if (push) begin
      if (m_stack.size() == DP) evt = 1;
      else m_stack.push_back(m_flags);
    end else if (pop) begin
      if (m_stack.size() == 0) evt = 1;
      else begin nf = m_stack.pop_back(); popped = 1; end
    end
`endif
    if (!popped && en) nf = in_v;
    if (m_irq) begin
      if (ack) begin m_irq = 0; m_cool = 1; ns = ns & ~mask; end
      else if (!pend) m_irq = 0;
    end else if (m_cool > 0) m_cool--;
    else if (pend) m_irq = 1;
    if (clr) begin ns = '0; nerr = 0; end
    if (en) ns = ns | in_v;
    if (evt) nerr = 1;
    m_flags = nf; m_sticky = ns; m_err = nerr;
  endtask

  task automatic check_model(input string tag);
    bit ef, ee;
`ifdef FLAGS_STACK_EN
    ef = (m_stack.size() == DP);
    ee = (m_stack.size() == 0);
`else
    ef = 0;
    ee = 1;
`endif
    check({tag, ".flags"},  32'(flags),  32'(m_flags));
    check({tag, ".sticky"}, 32'(sticky), 32'(m_sticky));
    check({tag, ".irq"},    32'(irq),    32'(m_irq));
    check({tag, ".full"},   32'(full),   32'(ef));
    check({tag, ".empty"},  32'(empty),  32'(ee));
    check({tag, ".err"},    32'(err),    32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit e, input logic [NF-1:0] i, input bit pu, input bit po,
                       input bit c, input logic [NF-1:0] mk, input bit a);
    en = e; in_v = i; push = pu; pop = po; clr = c; mask = mk; ack = a;
  endtask

  initial begin
    tbl[0]  = '{1, 4'h1, 0, 0, 0, 4'h0, 0, 4'h1, 4'h1, 0};
    tbl[1]  = '{1, 4'h4, 0, 0, 0, 4'h0, 0, 4'h4, 4'h5, 0};
    tbl[2]  = '{1, 4'h2, 0, 0, 1, 4'h0, 0, 4'h2, 4'h2, 0};
    tbl[3]  = '{0, 4'h0, 0, 0, 1, 4'h0, 0, 4'h2, 4'h0, 0};
    tbl[4]  = '{1, 4'h1, 0, 0, 0, 4'h1, 0, 4'h1, 4'h1, 0};
    tbl[5]  = '{0, 4'h0, 0, 0, 0, 4'h1, 0, 4'h1, 4'h1, 1};
    tbl[6]  = '{0, 4'h0, 0, 0, 0, 4'h1, 0, 4'h1, 4'h1, 1};
    tbl[7]  = '{1, 4'h1, 0, 0, 0, 4'h1, 1, 4'h1, 4'h1, 0};
    tbl[8]  = '{0, 4'h0, 0, 0, 0, 4'h1, 0, 4'h1, 4'h1, 0};
    tbl[9]  = '{0, 4'h0, 0, 0, 0, 4'h1, 0, 4'h1, 4'h1, 1};
    tbl[10] = '{0, 4'h0, 0, 0, 0, 4'h1, 1, 4'h1, 4'h0, 0};
    tbl[11] = '{0, 4'h0, 0, 0, 0, 4'h1, 0, 4'h1, 4'h0, 0};
    tbl[12] = '{0, 4'h0, 0, 0, 0, 4'h1, 0, 4'h1, 4'h0, 0};
    tbl[13] = '{1, 4'h8, 0, 0, 0, 4'h1, 1, 4'h8, 4'h8, 0};
    tbl[14] = '{0, 4'h0, 0, 0, 0, 4'h8, 0, 4'h8, 4'h8, 1};
    tbl[15] = '{0, 4'h0, 0, 0, 1, 4'h8, 0, 4'h8, 4'h0, 1};
    tbl[16] = '{0, 4'h0, 0, 0, 0, 4'h8, 0, 4'h8, 4'h0, 0};
    tbl[17] = '{0, 4'h0, 1, 0, 0, 4'h0, 0, 4'h8, 4'h0, 0};
    tbl[18] = '{0, 4'h0, 0, 1, 0, 4'h0, 0, 4'h8, 4'h0, 0};
    tbl[19] = '{0, 4'h0, 1, 1, 0, 4'h0, 0, 4'h8, 4'h0, 0};

    model_reset();
    tick(); tick();
    check("reset.flags", 32'(flags), 32'h0);
    check("reset.sticky", 32'(sticky), 32'h0);
    check("reset.irq", 32'(irq), 32'h0);
    check("reset.empty", 32'(empty), 32'h1);
    check("reset.full", 32'(full), 32'h0);
    check("reset.err", 32'(err), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 20; v++) begin
      drive(tbl[v].en, tbl[v].in, tbl[v].push, tbl[v].pop, tbl[v].clr, tbl[v].mask, tbl[v].ack);
      tick();
      check($sformatf("vec%0d.flags", v), 32'(flags), 32'(tbl[v].ef));
      check($sformatf("vec%0d.sticky", v), 32'(sticky), 32'(tbl[v].es));
      check($sformatf("vec%0d.irq", v), 32'(irq), 32'(tbl[v].ei));
    end
`ifdef FLAGS_STACK_EN
    check("vec.err_after_conflict", 32'(err), 32'h1);
`else
    check("vec.err_macro_off", 32'(err), 32'h0);
`endif
    drive(0, 4'h0, 0, 0, 1, 4'h0, 0); tick();
    check("clr.err", 32'(err), 32'h0);

    // Reset in the middle of activity, asserted between clock edges.
    drive(1, 4'hA, 0, 0, 0, 4'hF, 0); tick();
    drive(0, 4'h0, 1, 0, 0, 4'hF, 0); tick();
    drive(0, 4'h0, 1, 0, 0, 4'hF, 0); tick();
    drive(0, 4'h0, 0, 0, 0, 4'hF, 0); tick();
    check("midop.flags", 32'(flags), 32'hA);
    check("midop.irq", 32'(irq), 32'h1);
`ifdef FLAGS_STACK_EN
    check("midop.empty", 32'(empty), 32'h0);
`endif
    #2 rst = 1'b1;
    #1 model_reset();
    check("async_rst.flags", 32'(flags), 32'h0);
    check("async_rst.sticky", 32'(sticky), 32'h0);
    check("async_rst.irq", 32'(irq), 32'h0);
    check("async_rst.empty", 32'(empty), 32'h1);
    check("async_rst.full", 32'(full), 32'h0);
    check("async_rst.err", 32'(err), 32'h0);
    #1 rst = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 4'h0, 0);
    tick();

`ifdef FLAGS_STACK_EN
    drive(1, 4'h3, 0, 0, 0, 4'h0, 0); tick();
    drive(1, 4'h8, 1, 0, 0, 4'h0, 0); tick();
    check("stk.push_en.flags", 32'(flags), 32'h8);
    check("stk.push_en.empty", 32'(empty), 32'h0);
    drive(0, 4'h0, 0, 1, 0, 4'h0, 0); tick();
    check("stk.pop.flags", 32'(flags), 32'h3);
    check("stk.pop.empty", 32'(empty), 32'h1);
    for (int k = 0; k < DP; k++) begin
      drive(0, 4'h0, 1, 0, 0, 4'h0, 0); tick();
    end
    check("stk.fill.full", 32'(full), 32'h1);
    check("stk.fill.err", 32'(err), 32'h0);
    drive(0, 4'h0, 1, 0, 0, 4'h0, 0); tick();
    check("stk.overflow.err", 32'(err), 32'h1);
    check("stk.overflow.full", 32'(full), 32'h1);
    drive(0, 4'h0, 0, 1, 0, 4'h0, 0); tick();
    check("stk.after_ovf_pop.full", 32'(full), 32'h0);
    for (int k = 0; k < DP - 1; k++) begin
      drive(0, 4'h0, 0, 1, 0, 4'h0, 0); tick();
    end
    check("stk.drain.empty", 32'(empty), 32'h1);
    check("stk.drain.flags", 32'(flags), 32'h3);
    drive(0, 4'h0, 0, 0, 1, 4'h0, 0); tick();
    drive(0, 4'h0, 0, 1, 0, 4'h0, 0); tick();
    check("stk.underflow.err", 32'(err), 32'h1);
    check("stk.underflow.flags", 32'(flags), 32'h3);
    drive(0, 4'h0, 0, 0, 1, 4'h0, 0); tick();
    drive(0, 4'h0, 1, 1, 0, 4'h0, 0); tick();
    check("stk.conflict.err", 32'(err), 32'h1);
    check("stk.conflict.empty", 32'(empty), 32'h1);
`else
    drive(1, 4'h5, 0, 0, 0, 4'h0, 0); tick();
    drive(0, 4'h0, 1, 0, 0, 4'h0, 0); tick();
    drive(0, 4'h0, 0, 1, 0, 4'h0, 0); tick();
    drive(0, 4'h0, 1, 1, 0, 4'h0, 0); tick();
    check("nostk.flags", 32'(flags), 32'h5);
    check("nostk.empty", 32'(empty), 32'h1);
    check("nostk.full", 32'(full), 32'h0);
    check("nostk.err", 32'(err), 32'h0);
`endif

    for (int r = 0; r < 400; r++) begin
      drive($urandom_range(1, 0) == 1, NF'($urandom), $urandom_range(3, 0) == 0,
            $urandom_range(3, 0) == 0, $urandom_range(15, 0) == 0, NF'($urandom),
            $urandom_range(2, 0) == 0);
      tick();
      check_model($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
